// File: rtl/tdc_coarse_counter.sv
// Coarse TDC interval counter: counts quad-clock cycles from a start rising edge
// to a stop rising edge and holds the result for the DAQ with a valid/ack handshake.
module tdc_coarse_counter #(
  parameter int BIT_COUNT      = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_ack,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [BIT_COUNT-1:0] o_count,
  output logic                 o_timeout,
  output logic                 o_overrun,
  output logic [7:0]           o_meas_id
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_t;

  localparam logic [BIT_COUNT-1:0] TIMEOUT_VAL = BIT_COUNT'(TIMEOUT_CYCLES);

  state_t               state, state_nxt;
  logic [BIT_COUNT-1:0] counter, counter_nxt;
  logic [BIT_COUNT-1:0] count_nxt;
  logic                 timeout_nxt;
  logic                 overrun_nxt;
  logic [7:0]           meas_id_nxt;
  logic                 start_d, stop_d;
  logic                 start_rise, stop_rise;

  assign start_rise = i_start & ~start_d;
  assign stop_rise  = i_stop & ~stop_d;
  assign o_busy     = (state == COUNT);
  assign o_valid    = (state == HOLD);

  // NOTE: every value produced here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    count_nxt   = o_count;
    timeout_nxt = o_timeout;
    overrun_nxt = o_overrun;
    meas_id_nxt = o_meas_id;
    case (state)
      IDLE: begin
        if (i_enable && start_rise) begin
          counter_nxt = BIT_COUNT'(1);
          state_nxt   = COUNT;
        end
      end
      COUNT: begin
        if (start_rise) overrun_nxt = 1'b1;
        if (!i_enable) begin
          counter_nxt = '0;
          state_nxt   = IDLE;
        end else if (stop_rise) begin
          // Stop wins over timeout when both land in the same cycle.
          count_nxt   = counter;
          timeout_nxt = 1'b0;
          meas_id_nxt = o_meas_id + 8'd1;
          state_nxt   = HOLD;
        end else if (counter == TIMEOUT_VAL) begin
          count_nxt   = counter;
          timeout_nxt = 1'b1;
          meas_id_nxt = o_meas_id + 8'd1;
          state_nxt   = HOLD;
        end else begin
          counter_nxt = counter + BIT_COUNT'(1);
        end
      end
      HOLD: begin
        // A start edge coinciding with ack is still dropped.
        if (start_rise) overrun_nxt = 1'b1;
        if (i_ack) begin
          timeout_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    start_d <= i_start;
    stop_d  <= i_stop;
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      o_count   <= '0;
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
      o_meas_id <= 8'd0;
    end else begin
      state     <= state_nxt;
      counter   <= counter_nxt;
      o_count   <= count_nxt;
      o_timeout <= timeout_nxt;
      o_overrun <= overrun_nxt;
      o_meas_id <= meas_id_nxt;
    end
  end

endmodule

// File: tb/tb_tdc_coarse_counter.sv
// Directed bench for tdc_coarse_counter: a default instance (timeout 1000) and a
// short-timeout instance (timeout 16) share all inputs.
module tb_tdc_coarse_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable, i_start, i_stop, i_ack;
  logic        o_busy, o_valid, o_timeout, o_overrun;
  logic [31:0] o_count;
  logic [7:0]  o_meas_id;
  logic        s_busy, s_valid, s_timeout, s_overrun;
  logic [31:0] s_count;
  logic [7:0]  s_meas_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdc_coarse_counter #(.BIT_COUNT(32), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_start(i_start),
    .i_stop(i_stop), .i_ack(i_ack), .o_busy(o_busy), .o_valid(o_valid),
    .o_count(o_count), .o_timeout(o_timeout), .o_overrun(o_overrun),
    .o_meas_id(o_meas_id)
  );

  tdc_coarse_counter #(.BIT_COUNT(32), .TIMEOUT_CYCLES(16)) dut16 (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_start(i_start),
    .i_stop(i_stop), .i_ack(i_ack), .o_busy(s_busy), .o_valid(s_valid),
    .o_count(s_count), .o_timeout(s_timeout), .o_overrun(s_overrun),
    .o_meas_id(s_meas_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lower both levels, then a start edge and a stop edge n cycles later.
  task automatic run_meas(input int n);
    i_start = 1'b0; i_stop = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    repeat (n - 1) tick();
    i_stop = 1'b1;
    tick();
  endtask

  task automatic do_ack();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if ({o_busy, o_valid, o_timeout, o_overrun} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {o_busy, o_valid, o_timeout, o_overrun}); end
    checks++; if (o_count !== 32'd0 || o_meas_id !== 8'd0) begin failures++; $display("FAIL reset_count_id got=%0d/%0d exp=0/0", o_count, o_meas_id); end
    checks++; if ({s_busy, s_valid, s_timeout, s_overrun} !== 4'b0 || s_count !== 32'd0) begin failures++; $display("FAIL reset_dut16 got=%b/%0d exp=0000/0", {s_busy, s_valid, s_timeout, s_overrun}, s_count); end
  endtask

  task automatic test_basic();
    i_start = 1'b0; i_stop = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    repeat (36) tick();
    checks++; if (o_busy !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL basic_pre_stop got=busy%b valid%b exp=busy1 valid0", o_busy, o_valid); end
    checks++; if (s_valid !== 1'b1 || s_count !== 32'd16 || s_timeout !== 1'b1) begin failures++; $display("FAIL basic_dut16_timeout got=%b/%0d/%b exp=1/16/1", s_valid, s_count, s_timeout); end
    i_stop = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b1 || o_count !== 32'd37) begin failures++; $display("FAIL basic_result got=valid%b count%0d exp=valid1 count37", o_valid, o_count); end
    checks++; if (o_timeout !== 1'b0 || o_meas_id !== 8'd1) begin failures++; $display("FAIL basic_tmo_id got=%b/%0d exp=0/1", o_timeout, o_meas_id); end
    tick();
    do_ack();
    checks++; if (o_valid !== 1'b0 || o_count !== 32'd37) begin failures++; $display("FAIL basic_ack got=valid%b count%0d exp=valid0 count37", o_valid, o_count); end
    checks++; if (s_valid !== 1'b0 || s_timeout !== 1'b0) begin failures++; $display("FAIL basic_ack_dut16 got=valid%b tmo%b exp=0/0", s_valid, s_timeout); end
  endtask

  task automatic test_minimum();
    run_meas(1);
    checks++; if (o_valid !== 1'b1 || o_count !== 32'd1 || o_meas_id !== 8'd2) begin failures++; $display("FAIL min_count got=%b/%0d/%0d exp=1/1/2", o_valid, o_count, o_meas_id); end
    do_ack();
  endtask

  task automatic test_simultaneous();
    i_start = 1'b0; i_stop = 1'b0;
    tick();
    i_start = 1'b1; i_stop = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL simul_started got=%b exp=1", o_busy); end
    repeat (16) tick();
    checks++; if (s_valid !== 1'b1 || s_count !== 32'd16 || s_timeout !== 1'b1) begin failures++; $display("FAIL simul_dut16 got=%b/%0d/%b exp=1/16/1", s_valid, s_count, s_timeout); end
    repeat (983) tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL simul_pre_timeout got=%b exp=0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_count !== 32'd1000 || o_timeout !== 1'b1 || o_meas_id !== 8'd3) begin failures++; $display("FAIL simul_timeout got=%b/%0d/%b/%0d exp=1/1000/1/3", o_valid, o_count, o_timeout, o_meas_id); end
    do_ack();
    checks++; if (o_timeout !== 1'b0 || o_valid !== 1'b0) begin failures++; $display("FAIL simul_ack_clear got=tmo%b valid%b exp=0/0", o_timeout, o_valid); end
  endtask

  task automatic test_timeout_vs_stop();
    run_meas(16);
    checks++; if (s_valid !== 1'b1 || s_count !== 32'd16 || s_timeout !== 1'b0) begin failures++; $display("FAIL stop_at_limit got=%b/%0d/%b exp=1/16/0", s_valid, s_count, s_timeout); end
    checks++; if (s_meas_id !== 8'd4 || o_count !== 32'd16) begin failures++; $display("FAIL stop_at_limit_id got=%0d/%0d exp=4/16", s_meas_id, o_count); end
    do_ack();
    run_meas(17);
    checks++; if (s_count !== 32'd16 || s_timeout !== 1'b1) begin failures++; $display("FAIL limit_plus1 got=%0d/%b exp=16/1", s_count, s_timeout); end
    checks++; if (o_count !== 32'd17 || o_timeout !== 1'b0 || o_meas_id !== 8'd5) begin failures++; $display("FAIL limit_plus1_dflt got=%0d/%b/%0d exp=17/0/5", o_count, o_timeout, o_meas_id); end
    do_ack();
    checks++; if (s_timeout !== 1'b0) begin failures++; $display("FAIL limit_ack_clear got=%b exp=0", s_timeout); end
  endtask

  task automatic test_overrun();
    i_start = 1'b0; i_stop = 1'b0;
    tick();
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%b exp=0", o_overrun); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    checks++; if (o_overrun !== 1'b1 || o_busy !== 1'b1) begin failures++; $display("FAIL overrun_count got=ovr%b busy%b exp=1/1", o_overrun, o_busy); end
    i_stop = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b1 || o_count !== 32'd3) begin failures++; $display("FAIL overrun_result got=%b/%0d exp=1/3", o_valid, o_count); end
    i_start = 1'b0; i_stop = 1'b0;
    tick();
    i_start = 1'b1; i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_overrun !== 1'b1) begin failures++; $display("FAIL overrun_ack_start got=busy%b valid%b ovr%b exp=0/0/1", o_busy, o_valid, o_overrun); end
    run_meas(4);
    checks++; if (o_count !== 32'd4 || o_meas_id !== 8'd7 || o_overrun !== 1'b1 || s_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%0d/%0d/%b/%b exp=4/7/1/1", o_count, o_meas_id, o_overrun, s_overrun); end
    do_ack();
  endtask

  task automatic test_abort();
    i_start = 1'b0; i_stop = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    repeat (3) tick();
    i_enable = 1'b0;
    tick();
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_meas_id !== 8'd7) begin failures++; $display("FAIL abort got=busy%b valid%b id%0d exp=0/0/7", o_busy, o_valid, o_meas_id); end
    i_start = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    tick();
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin failures++; $display("FAIL disabled_start got=busy%b valid%b exp=0/0", o_busy, o_valid); end
    i_enable = 1'b1;
    i_start = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_hold();
    i_start = 1'b1;
    tick();
    tick();
    i_stop = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b1 || o_count !== 32'd2) begin failures++; $display("FAIL hold_before_reset got=%b/%0d exp=1/2", o_valid, o_count); end
    do_reset();
    tick();
    tick();
    checks++; if ({o_busy, o_valid, o_timeout, o_overrun} !== 4'b0 || o_count !== 32'd0 || o_meas_id !== 8'd0) begin failures++; $display("FAIL reset_hold got=%b/%0d/%0d exp=0000/0/0", {o_busy, o_valid, o_timeout, o_overrun}, o_count, o_meas_id); end
    i_start = 1'b0; i_stop = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL restart_after_reset got=%b exp=1", o_busy); end
    i_stop = 1'b1;
    tick();
    checks++; if (o_count !== 32'd1 || o_meas_id !== 8'd1) begin failures++; $display("FAIL post_reset_meas got=%0d/%0d exp=1/1", o_count, o_meas_id); end
    do_ack();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_id;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      exp_id = 8'((i + 1) % 256);
      run_meas(2);
      checks++; if (o_meas_id !== exp_id || s_meas_id !== exp_id) begin failures++; $display("FAIL wrap_id[%0d] got=%0d/%0d exp=%0d", i, o_meas_id, s_meas_id, exp_id); end
      do_ack();
    end
    checks++; if (o_count !== 32'd2) begin failures++; $display("FAIL wrap_last_count got=%0d exp=2", o_count); end
  endtask

  initial begin
    reset = 1'b1; i_enable = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_ack = 1'b0;
    test_reset();
    test_basic();
    test_minimum();
    test_simultaneous();
    test_timeout_vs_stop();
    test_overrun();
    test_abort();
    test_reset_in_hold();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
